compare_concat_seq_ctrl: RTL and testbench



---
 rtl/compare_concat_seq_ctrl_pkg.sv | 15 +
 rtl/compare_concat_seq_ctrl_core.sv | 18 +
 rtl/compare_concat_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_compare_concat_seq_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/compare_concat_seq_ctrl_pkg.sv
// Shared definitions for the rotated-concatenation comparator controller:
// FSM state encoding and default widths.
package compare_concat_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_C   = 2'd2,
    S_OUT = 2'd3
  } state_t;

  localparam int DEF_W     = 2;
  localparam int DEF_CNT_W = 8;

endpackage : compare_concat_seq_ctrl_pkg

// File: rtl/compare_concat_seq_ctrl_core.sv
// Combinational comparator: reports whether {a,b,c} equals its rotation {b,c,a}.
module compare_concat_core #(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic         eq
);

  logic [3*W-1:0] abc_s;
  logic [3*W-1:0] bca_s;

  assign abc_s = {a, b, c};
  assign bca_s = {b, c, a};
  assign eq    = (abc_s == bca_s);

endmodule : compare_concat_core

// File: rtl/compare_concat_seq_ctrl.sv
// Sequencing controller: collects three symbols over valid/ready, compares
// {a,b,c} with {b,c,a}, holds the result until accepted and keeps statistics.
module compare_concat_seq_ctrl
  import compare_concat_seq_ctrl_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic [3*W-1:0]   out_abc,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] triple_count,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [3*W-1:0]   abc_q, abc_d;
  logic             result_q, result_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] triple_q, triple_d;
  logic             cmp_eq_s;

  // The comparator always looks at the candidate triple completed by the current symbol.
  compare_concat_core #(.W(W)) u_core (
    .a  (a_q),
    .b  (b_q),
    .c  (in_data),
    .eq (cmp_eq_s)
  );

  // Next-state, datapath and counter updates.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    abc_d    = abc_q;
    result_d = result_q;
    match_d  = match_q;
    triple_d = triple_q;
    case (state_q)
      S_A: begin
        if (in_valid) begin
          a_d     = in_data;
          state_d = S_B;
        end else begin
          state_d = S_A;
        end
      end
      S_B: begin
        if (in_valid) begin
          b_d     = in_data;
          state_d = S_C;
        end else begin
          state_d = S_B;
        end
      end
      S_C: begin
        if (in_valid) begin
          abc_d    = {a_q, b_q, in_data};
          result_d = cmp_eq_s;
          state_d  = S_OUT;
        end else begin
          state_d = S_C;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          triple_d = triple_q + CNT_W'(1);
          // match_count saturates instead of wrapping.
          if (result_q && (match_q != {CNT_W{1'b1}})) begin
            match_d = match_q + CNT_W'(1);
          end else begin
            match_d = match_q;
          end
          state_d = S_A;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_A;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      abc_q    <= '0;
      result_q <= 1'b0;
      match_q  <= '0;
      triple_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      abc_q    <= abc_d;
      result_q <= result_d;
      match_q  <= match_d;
      triple_q <= triple_d;
    end
  end

  assign in_ready     = (state_q != S_OUT);
  assign out_valid    = (state_q == S_OUT);
  assign busy         = (state_q != S_A);
  assign out_result   = result_q;
  assign out_abc      = abc_q;
  assign match_count  = match_q;
  assign triple_count = triple_q;

endmodule : compare_concat_seq_ctrl

// File: tb/tb_compare_concat_seq_ctrl.sv
// Bench for compare_concat_seq_ctrl: directed scenarios plus random traffic,
// checked every cycle against a symbol-list reference model.
module tb_compare_concat_seq_ctrl;

  localparam int W    = 2;
  localparam int CW   = 3;
  localparam int CMOD = 8;
  localparam int CMAX = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_result;
  logic [3*W-1:0]  out_abc;
  logic [CW-1:0]   match_count;
  logic [CW-1:0]   triple_count;
  logic            busy;

  int total = 0;
  int bad   = 0;

  // Reference model: symbols collected so far, pending result, statistics.
  int             held;
  logic [W-1:0]   sym[2];
  logic           pend;
  logic [3*W-1:0] m_abc;
  logic           m_res;
  int             m_trip;
  int             m_match;

  always #5 clk = ~clk;

  compare_concat_seq_ctrl #(.W(W), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_abc      (out_abc),
    .match_count  (match_count),
    .triple_count (triple_count),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic r, input logic v, input logic [W-1:0] d, input logic ordy);
    logic [3*W-1:0] rot;
    rst = r; in_valid = v; in_data = d; out_ready = ordy;
    @(negedge clk);
    chk("in_ready",     32'(in_ready),     32'(!pend));
    chk("out_valid",    32'(out_valid),    32'(pend));
    chk("busy",         32'(busy),         32'(pend || held != 0));
    chk("triple_count", 32'(triple_count), 32'(m_trip));
    chk("match_count",  32'(match_count),  32'(m_match));
    chk("out_result",   32'(out_result),   32'(m_res));
    chk("out_abc",      32'(out_abc),      32'(m_abc));
    @(posedge clk);
    if (r) begin
      held = 0; pend = 1'b0; m_abc = '0; m_res = 1'b0; m_trip = 0; m_match = 0;
    end else if (pend) begin
      if (ordy) begin
        m_trip = (m_trip + 1) % CMOD;
        if (m_res && m_match < CMAX) m_match = m_match + 1;
        pend = 1'b0;
      end
    end else if (v) begin
      if (held < 2) begin
        sym[held] = d;
        held = held + 1;
      end else begin
        m_abc = {sym[0], sym[1], d};
        rot   = {sym[1], d, sym[0]};
        m_res = (m_abc == rot);
        pend  = 1'b1;
        held  = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b1, 1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    logic [W-1:0] s;
    held = 0; pend = 1'b0; m_abc = '0; m_res = 1'b0; m_trip = 0; m_match = 0;
    sym[0] = '0; sym[1] = '0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();
    chk("rst_abc", 32'(out_abc), 32'd0);
    chk("rst_state_busy", 32'(busy), 32'd0);

    // Back-to-back triple 01,10,11 with out_ready held high.
    step(1'b0, 1'b1, 2'b01, 1'b1);
    step(1'b0, 1'b1, 2'b10, 1'b1);
    step(1'b0, 1'b1, 2'b11, 1'b1);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_abc", 32'(out_abc), 32'h1b);
    chk("t1_res", 32'(out_result), 32'd0);
    step(1'b0, 1'b0, 2'b00, 1'b1);
    chk("t1_trip", 32'(triple_count), 32'd1);
    chk("t1_match", 32'(match_count), 32'd0);

    // Two triples with the consumer stalling five cycles each.
    do_reset();
    step(1'b0, 1'b1, 2'b11, 1'b0);
    step(1'b0, 1'b1, 2'b00, 1'b0);
    step(1'b0, 1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, W'($urandom_range(3)), 1'b0);
    chk("t2_abc0", 32'(out_abc), 32'h31);
    step(1'b0, 1'b1, 2'b10, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b10, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, W'($urandom_range(3)), 1'b0);
    chk("t2_abc1", 32'(out_abc), 32'h2a);
    chk("t2_res1", 32'(out_result), 32'd1);
    step(1'b0, 1'b0, 2'b00, 1'b1);
    chk("t2_trip", 32'(triple_count), 32'd2);
    chk("t2_match", 32'(match_count), 32'd1);

    // Gapped input: one transfer every third cycle.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, W'($urandom_range(3)), 1'b1);
      step(1'b0, 1'b0, W'($urandom_range(3)), 1'b1);
      step(1'b0, 1'b1, 2'b01, 1'b1);
    end
    chk("gap_abc", 32'(out_abc), 32'h15);
    chk("gap_res", 32'(out_result), 32'd1);
    step(1'b0, 1'b0, 2'b00, 1'b1);

    // Reset after two symbols discards the partial triple.
    do_reset();
    step(1'b0, 1'b1, 2'b10, 1'b1);
    step(1'b0, 1'b1, 2'b10, 1'b1);
    step(1'b1, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b00, 1'b1);
    chk("mid_abc", 32'(out_abc), 32'd0);
    chk("mid_res", 32'(out_result), 32'd1);
    step(1'b0, 1'b0, 2'b00, 1'b1);
    chk("mid_trip", 32'(triple_count), 32'd1);
    chk("mid_match", 32'(match_count), 32'd1);

    // Ten matching triples: triple_count wraps, match_count saturates.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      s = W'($urandom_range(3));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, s, 1'b1);
      step(1'b0, 1'b0, 2'b00, 1'b1);
    end
    chk("wrap_trip", 32'(triple_count), 32'd2);
    chk("sat_match", 32'(match_count), 32'd7);

    // Reset in the same cycle as the output handshake wins.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b11, 1'b1);
    step(1'b1, 1'b1, 2'b11, 1'b1);
    chk("rwin_valid", 32'(out_valid), 32'd0);
    chk("rwin_trip", 32'(triple_count), 32'd0);
    chk("rwin_match", 32'(match_count), 32'd0);
    chk("rwin_busy", 32'(busy), 32'd0);

    // Random traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(3) != 0),
           W'($urandom_range(3)), 1'($urandom_range(1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_compare_concat_seq_ctrl
